ifft_butterfly_pipe: RTL and testbench

Pipelined radix-2 decimation-in-time inverse butterfly for the IFFT path, the inverse counterpart of the combinational forward DIF butterfly in the FFT datapath. Accepts one complex pair plus twiddle per cycle over a valid/ready handshake. Computes `out1 = a + conj(W)·b` and `out2 = a − conj(W)·b` in 16-bit sign-magnitude Q7.8, and presents results three cycles later with full backpressure.

---
 rtl/ifft_butterfly_pipe_pkg.sv | 53 +++++
 rtl/ifft_butterfly_pipe_if.sv | 26 ++
 rtl/ifft_butterfly_pipe_sm_mult.sv | 23 ++
 rtl/ifft_butterfly_pipe.sv | 135 +++++++++++++
 tb/tb_ifft_butterfly_pipe.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/ifft_butterfly_pipe_pkg.sv
// Shared sign-magnitude Q7.8 types, constants and arithmetic helpers for the
// IFFT butterfly datapath. Words are 16 bits: bit 15 sign, bits 14:0 magnitude
// in units of 2^-8. Negative zero is accepted on input but never produced.
package ifft_pkg;

  typedef logic [15:0] sm16_t;

  typedef struct packed {
    sm16_t re;
    sm16_t im;
  } cplx_t;

  // Result of a saturating sign-magnitude operation.
  typedef struct packed {
    logic  sat;
    sm16_t val;
  } sm_res_t;

  localparam sm16_t       SM_ONE     = 16'h0100;
  localparam logic [14:0] SM_MAX_MAG = 15'h7FFF;
  localparam int          FRAC_BITS  = 8;

  // Negate; zero (of either sign) always comes back as +0.
  function automatic sm16_t sm_neg(input sm16_t x);
    return (x[14:0] == '0) ? '0 : {~x[15], x[14:0]};
  endfunction

  // Sign-magnitude add: like signs add and saturate, unlike signs subtract the
  // smaller magnitude from the larger and keep the larger operand's sign.
  function automatic sm_res_t sm_add(input sm16_t x, input sm16_t y);
    sm_res_t     r;
    logic [15:0] sum;
    logic [14:0] mag;
    logic        sgn;
    r.sat = 1'b0;
    sum   = '0;
    if (x[15] == y[15]) begin
      sum   = {1'b0, x[14:0]} + {1'b0, y[14:0]};
      r.sat = sum[15];
      mag   = sum[15] ? SM_MAX_MAG : sum[14:0];
      sgn   = x[15];
    end else if (x[14:0] >= y[14:0]) begin
      mag = x[14:0] - y[14:0];
      sgn = x[15];
    end else begin
      mag = y[14:0] - x[14:0];
      sgn = y[15];
    end
    r.val = (mag == '0) ? '0 : {sgn, mag};
    return r;
  endfunction

endpackage

// File: rtl/ifft_butterfly_pipe_if.sv
// Handshake and data bundle of the IFFT butterfly. The master side supplies
// operands and downstream readiness; the slave side is the butterfly itself.
interface ifft_butterfly_pipe_if;
  import ifft_pkg::*;

  logic  in_valid;
  logic  in_ready;
  sm16_t a_re, a_im, b_re, b_im;
  sm16_t w_re, w_im;
  logic  out_valid;
  logic  out_ready;
  sm16_t o1_re, o1_im, o2_re, o2_im;
  logic  sat_flag;
  logic  sat_clear;

  modport master (
    output in_valid, a_re, a_im, b_re, b_im, w_re, w_im, out_ready, sat_clear,
    input  in_ready, out_valid, o1_re, o1_im, o2_re, o2_im, sat_flag
  );

  modport slave (
    input  in_valid, a_re, a_im, b_re, b_im, w_re, w_im, out_ready, sat_clear,
    output in_ready, out_valid, o1_re, o1_im, o2_re, o2_im, sat_flag
  );

endinterface

// File: rtl/ifft_butterfly_pipe_sm_mult.sv
// Combinational sign-magnitude Q7.8 multiplier. The 30-bit magnitude product
// is truncated to Q7.8; any integer overflow saturates to the largest magnitude.
module sm_mult
  import ifft_pkg::*;
(
  input  sm16_t x_i,
  input  sm16_t y_i,
  output sm16_t p_o,
  output logic  sat_o
);

  logic [29:0] prod;
  logic [14:0] mag;

  // Magnitude multiply, truncate, saturate and normalise zero to +0.
  always_comb begin
    prod  = x_i[14:0] * y_i[14:0];
    sat_o = |prod[29:FRAC_BITS+15];
    mag   = sat_o ? SM_MAX_MAG : prod[FRAC_BITS +: 15];
    p_o   = (mag == '0) ? '0 : {x_i[15] ^ y_i[15], mag};
  end

endmodule

// File: rtl/ifft_butterfly_pipe.sv
// Three-stage radix-2 DIT inverse butterfly: o1 = a + conj(W)*b,
// o2 = a - conj(W)*b, sign-magnitude Q7.8, valid/ready with full backpressure.
// Optional build macro IFFT_BFLY_SCALE_EN halves both outputs (truncating)
// after saturation detection, for the per-stage 1/2 IFFT normalisation.
module ifft_butterfly_pipe
  import ifft_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  ifft_butterfly_pipe_if.slave bus
);

`ifdef IFFT_BFLY_SCALE_EN
  function automatic sm16_t out_scale(input sm16_t x);
    logic [14:0] m;
    m = x[14:0] >> 1;
    return (m == '0) ? '0 : {x[15], m};
  endfunction
`else
  function automatic sm16_t out_scale(input sm16_t x);
    return x;
  endfunction
`endif

  logic adv;

  logic  vld_p0_q;
  cplx_t a_p0_q, b_p0_q, w_p0_q;

  sm16_t   p0, p1, p2, p3;
  logic    ms0, ms1, ms2, ms3;
  sm_res_t t_re_r, t_im_r;
  cplx_t   t_p1_d;
  logic    sat_p1;

  logic  vld_p1_q;
  cplx_t a_p1_q, t_p1_q;

  sm_res_t o1_re_r, o1_im_r, o2_re_r, o2_im_r;
  cplx_t   o1_p2_d, o2_p2_d;
  logic    sat_p2;

  logic  vld_p2_q;
  cplx_t o1_p2_q, o2_p2_q;

  logic sat_set;
  logic sat_flag_q, sat_flag_d;

  // Whole pipe advances unless a result is waiting on a stalled consumer.
  assign adv          = !vld_p2_q || bus.out_ready;
  assign bus.in_ready = adv;

  // ---- S1: capture operands and conjugated twiddle ----
  // Stage-1 data registers; contents only matter when vld_p0_q is set.
  always_ff @(posedge clk) begin
    if (adv) begin
      a_p0_q <= '{re: bus.a_re, im: bus.a_im};
      b_p0_q <= '{re: bus.b_re, im: bus.b_im};
      w_p0_q <= '{re: bus.w_re, im: {~bus.w_im[15], bus.w_im[14:0]}};
    end
  end

  // ---- S2: four products, combined into t = conj(W)*b ----
  sm_mult u_mult0 (.x_i(b_p0_q.re), .y_i(w_p0_q.re), .p_o(p0), .sat_o(ms0));
  sm_mult u_mult1 (.x_i(b_p0_q.im), .y_i(w_p0_q.im), .p_o(p1), .sat_o(ms1));
  sm_mult u_mult2 (.x_i(b_p0_q.re), .y_i(w_p0_q.im), .p_o(p2), .sat_o(ms2));
  sm_mult u_mult3 (.x_i(b_p0_q.im), .y_i(w_p0_q.re), .p_o(p3), .sat_o(ms3));

  // Complex product recombination and stage-2 saturation detect.
  always_comb begin
    t_re_r = sm_add(p0, sm_neg(p1));
    t_im_r = sm_add(p2, p3);
    t_p1_d = '{re: t_re_r.val, im: t_im_r.val};
    sat_p1 = ms0 | ms1 | ms2 | ms3 | t_re_r.sat | t_im_r.sat;
  end

  // Stage-2 data registers carry a alongside t.
  always_ff @(posedge clk) begin
    if (adv) begin
      a_p1_q <= a_p0_q;
      t_p1_q <= t_p1_d;
    end
  end

  // ---- S3: a +/- t, optional halving ----
  // Output sums; saturation is seen on the unscaled sums.
  always_comb begin
    o1_re_r = sm_add(a_p1_q.re, t_p1_q.re);
    o1_im_r = sm_add(a_p1_q.im, t_p1_q.im);
    o2_re_r = sm_add(a_p1_q.re, sm_neg(t_p1_q.re));
    o2_im_r = sm_add(a_p1_q.im, sm_neg(t_p1_q.im));
    o1_p2_d = '{re: out_scale(o1_re_r.val), im: out_scale(o1_im_r.val)};
    o2_p2_d = '{re: out_scale(o2_re_r.val), im: out_scale(o2_im_r.val)};
    sat_p2  = o1_re_r.sat | o1_im_r.sat | o2_re_r.sat | o2_im_r.sat;
  end

  // Sticky saturation: a set event wins over a simultaneous clear.
  always_comb begin
    sat_set    = adv && ((vld_p0_q && sat_p1) || (vld_p1_q && sat_p2));
    sat_flag_d = sat_flag_q;
    if (bus.sat_clear) sat_flag_d = 1'b0;
    if (sat_set)       sat_flag_d = 1'b1;
  end

  // Valid chain, output registers and flag; reset drops every in-flight slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0_q   <= 1'b0;
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      o1_p2_q    <= '0;
      o2_p2_q    <= '0;
      sat_flag_q <= 1'b0;
    end else begin
      sat_flag_q <= sat_flag_d;
      if (adv) begin
        vld_p0_q <= bus.in_valid;
        vld_p1_q <= vld_p0_q;
        vld_p2_q <= vld_p1_q;
        if (vld_p1_q) begin
          o1_p2_q <= o1_p2_d;
          o2_p2_q <= o2_p2_d;
        end
      end
    end
  end

  assign bus.out_valid = vld_p2_q;
  assign bus.o1_re     = o1_p2_q.re;
  assign bus.o1_im     = o1_p2_q.im;
  assign bus.o2_re     = o2_p2_q.re;
  assign bus.o2_im     = o2_p2_q.im;
  assign bus.sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_ifft_butterfly_pipe.sv
// Scoreboard bench for ifft_butterfly_pipe: directed vectors with hand-derived
// results; a monitor checks every presented output against the queue head.
`timescale 1ns/1ps
module tb_ifft_butterfly_pipe;
  import ifft_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifft_butterfly_pipe_if bus ();

  ifft_butterfly_pipe dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    sm16_t o1re, o1im, o2re, o2im;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_rx   = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Output halving applied by the scaled build.
  function automatic sm16_t scl(input sm16_t x);
`ifdef IFFT_BFLY_SCALE_EN
    logic [14:0] m;
    m = x[14:0] >> 1;
    return (m == '0) ? 16'h0000 : {x[15], m};
`else
    return x;
`endif
  endfunction

  function automatic exp_t mk(input sm16_t o1r, input sm16_t o1i, input sm16_t o2r, input sm16_t o2i);
    exp_t e;
    e.o1re = scl(o1r);
    e.o1im = scl(o1i);
    e.o2re = scl(o2r);
    e.o2im = scl(o2i);
    return e;
  endfunction

  // Present one pair at posedge+1; push its expectation when it is accepted.
  task automatic send(input sm16_t ar, input sm16_t ai, input sm16_t br, input sm16_t bi,
                      input sm16_t wr, input sm16_t wi, input exp_t e);
    int guard;
    guard        = 0;
    bus.in_valid = 1'b1;
    bus.a_re = ar; bus.a_im = ai;
    bus.b_re = br; bus.b_im = bi;
    bus.w_re = wr; bus.w_im = wi;
    @(negedge clk);
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stuck at 0");
    end else begin
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Monitor: compare whatever the DUT presents against the scoreboard head.
  initial begin : mon
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: o1_re %h with empty scoreboard", bus.o1_re);
        end else begin
          chk("o1_re", bus.o1_re, sb[0].o1re);
          chk("o1_im", bus.o1_im, sb[0].o1im);
          chk("o2_re", bus.o2_re, sb[0].o2re);
          chk("o2_im", bus.o2_im, sb[0].o2im);
          if (bus.out_ready) begin
            void'(sb.pop_front());
            n_rx++;
          end else begin
            chk("in_ready_stall", 16'(bus.in_ready), 16'h0000);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int rx0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.sat_clear = 1'b0;
    bus.a_re = '0; bus.a_im = '0; bus.b_re = '0; bus.b_im = '0;
    bus.w_re = '0; bus.w_im = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 16'(bus.out_valid), 16'h0000);
    chk("rst_sat_flag",  16'(bus.sat_flag),  16'h0000);
    chk("rst_in_ready",  16'(bus.in_ready),  16'h0001);
    chk("rst_o1_re", bus.o1_re, 16'h0000);
    chk("rst_o2_im", bus.o2_im, 16'h0000);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic: a = b = 1, W = 1, with latency probe (three register stages).
    send(16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000,
         mk(16'h0200, 16'h0000, 16'h0000, 16'h0000));
    @(negedge clk); chk("lat_edge1", 16'(bus.out_valid), 16'h0000);
    @(negedge clk); chk("lat_edge2", 16'(bus.out_valid), 16'h0000);
    @(negedge clk); chk("lat_edge3", 16'(bus.out_valid), 16'h0001);
    @(posedge clk); #1;

    // W = j: conj(W) = -j gives t = -j.
    send(16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0100,
         mk(16'h0100, 16'h8100, 16'h0100, 16'h0100));
    // Cancelling sum must be +0.
    send(16'h0080, 16'h0000, 16'h0080, 16'h0000, 16'h0100, 16'h0000,
         mk(16'h0100, 16'h0000, 16'h0000, 16'h0000));
    // Negative-zero inputs are plain zero.
    send(16'h8000, 16'h8000, 16'h0100, 16'h0000, 16'h0100, 16'h8000,
         mk(16'h0100, 16'h0000, 16'h8100, 16'h0000));
    repeat (5) @(posedge clk);
    #1;
    chk("sat_idle", 16'(bus.sat_flag), 16'h0000);

    // Saturating sum raises the sticky flag; clear drops it.
    send(16'h7F00, 16'h0000, 16'h7F00, 16'h0000, 16'h0100, 16'h0000,
         mk(16'h7FFF, 16'h0000, 16'h0000, 16'h0000));
    repeat (3) @(negedge clk);
    chk("sat_set", 16'(bus.sat_flag), 16'h0001);
    @(posedge clk); #1;
    bus.sat_clear = 1'b1;
    @(posedge clk); #1;
    bus.sat_clear = 1'b0;
    @(negedge clk);
    chk("sat_cleared", 16'(bus.sat_flag), 16'h0000);
    @(posedge clk); #1;

    // Clear held across the saturating edge: set wins.
    send(16'h7F00, 16'h0000, 16'h7F00, 16'h0000, 16'h0100, 16'h0000,
         mk(16'h7FFF, 16'h0000, 16'h0000, 16'h0000));
    @(posedge clk); #1;
    bus.sat_clear = 1'b1;
    @(posedge clk); #1;
    bus.sat_clear = 1'b0;
    @(negedge clk);
    chk("sat_set_vs_clear", 16'(bus.sat_flag), 16'h0001);
    @(posedge clk); #1;
    bus.sat_clear = 1'b1;
    @(posedge clk); #1;
    bus.sat_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back stream of 8 with a three-cycle output stall.
    rx0 = n_rx;
    fork
      begin
        for (int k = 1; k <= 8; k++)
          send(16'(k * 256), 16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000,
               mk(16'((k + 1) * 256), 16'h0000, 16'((k - 1) * 256), 16'h0000));
      end
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    chk("stream_count", 16'(n_rx - rx0), 16'd8);
    chk("stream_drained", 16'(sb.size()), 16'd0);

    // Reset with two pairs in flight: nothing stale may come out.
    send(16'h0300, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000,
         mk(16'h0400, 16'h0000, 16'h0200, 16'h0000));
    send(16'h0300, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000,
         mk(16'h0400, 16'h0000, 16'h0200, 16'h0000));
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 16'(bus.out_valid), 16'h0000);
    chk("midrst_o1_re", bus.o1_re, 16'h0000);
    chk("midrst_o2_re", bus.o2_re, 16'h0000);
    chk("midrst_in_ready", 16'(bus.in_ready), 16'h0001);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("postrst_out_valid", 16'(bus.out_valid), 16'h0000);
    chk("postrst_in_ready", 16'(bus.in_ready), 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
